shot_sequencer: RTL
===================

// Module: shot_sequencer
// PURPOSE
// - Light-gun shot controller: sequences pattern_gen through black/target flash frames on trigger pull,
//   samples photodiode detect during target frames, decides hit/miss, tracks score and shots per round.
// - Sits between vga (frame timing) and pattern_gen (drives its flash_mode select) in top.
// PARAMETERS
// - DEBOUNCE_CYCLES  250000  trigger must be stable this many clk cycles to register (10 ms @ 25 MHz)
// - BLACK_FRAMES     1       full black frames shown before target frames (1..3)
// - TARGET_FRAMES    1       frames with only the target lit white (1..3)
// - DETECT_MIN       16      detect-high valid-pixel cycles in target frames required for a hit
// - SHOTS            3       shots reloaded per round (1..3)
// - SCORE_W          8       score width
// PORTS
// - clk          in   1        pixel clock (mypll output)
// - reset        in   1        asynchronous, active-low reset
// - trigger      in   1        raw gun trigger, asynchronous, active-high
// - detect       in   1        raw photodiode, asynchronous, active-high
// - frame_start  in   1        1-cycle pulse from vga in vertical blanking, before first active pixel
// - valid        in   1        vga active-area flag
// - new_round    in   1        1-cycle pulse: reload shots_left
// - flash_mode   out  2        0=normal game, 1=all black, 2=target-only white (3 unused)
// - busy         out  1        shot sequence in progress
// - hit          out  1        1-cycle pulse: shot resolved as hit
// - miss         out  1        1-cycle pulse: shot resolved as miss
// - score        out  SCORE_W  hit count, saturating
// - shots_left   out  2        shots remaining this round
// BEHAVIOUR
// - Reset (async, reset==0): state IDLE, flash_mode=0, busy=0, hit=miss=0, score=0, shots_left=SHOTS,
//   sync/debounce state cleared (debounced trigger=0). Mid-sequence reset aborts immediately.
// - trigger, detect: 2-flop synchronisers. trigger debounced: counter restarts on any change of synced
//   value; debounced level updates after DEBOUNCE_CYCLES stable. press = debounced 0->1 edge (1 cycle).
// - FSM, all registered; outputs are registered, change on the edge that enters the state:
//   IDLE: busy=0, flash_mode=0. press && shots_left!=0 -> ARM, shots_left-=1. press otherwise ignored.
//   ARM: busy=1. frame_start -> BLACK, frame counter=0, detect counter=0.
//   BLACK: flash_mode=1. each frame_start increments frame counter; at BLACK_FRAMES -> TARGET, counter=0.
//   TARGET: flash_mode=2. det_cnt += (detect_sync && valid), saturating at DETECT_MIN.
//     frame_start ending frame TARGET_FRAMES -> RESOLVE.
//   RESOLVE (1 cycle): flash_mode=0; hit if det_cnt>=DETECT_MIN (and no cheat flag) else miss;
//     hit increments score, saturating at 2^SCORE_W-1. -> RELEASE.
//   RELEASE: busy=1 until debounced trigger==0, then -> IDLE (no auto-fire when held).
// - Presses while busy are discarded, never queued.
// - new_round: shots_left<=SHOTS in any state; if coincident with a decrement, reload wins;
//   score unaffected. Coincident hit still scores.
// - frame_start pulse while in IDLE/RESOLVE/RELEASE ignored. det_cnt frozen outside TARGET.
// - Latency: press edge -> ARM 1 cycle; flash_mode=1 one cycle after first frame_start in ARM;
//   hit/miss one cycle after final target-frame frame_start.
// CONFIGURATION
// - BLACK_FRAME_CHECK_EN defined: any detect_sync&&valid during BLACK sets cheat flag (cleared in ARM);
//   cheat forces miss in RESOLVE regardless of det_cnt.
// - Undefined: detect ignored during BLACK; hit decided by det_cnt only. No cheat flag logic synthesised.
// TESTING (DEBOUNCE_CYCLES=4, DETECT_MIN=16, BLACK_FRAMES=TARGET_FRAMES=1, SHOTS=3, short vga frames)
// - Reset then idle: flash_mode=0, score=0, shots_left=3, busy=0, no hit/miss for 1000 cycles.
// - Clean press, detect high 20 valid cycles in target frame -> flash 0->1->2->0, one hit, score=1,
//   shots_left=2; busy stays 1 until trigger released.
// - Press, detect high only 15 cycles in target frame -> one miss, score unchanged, shots_left=2.
// - Trigger bounce (3-cycle pulses) -> no press; 4 presses in a round -> 3 sequences, 4th ignored,
//   shots_left=0; new_round pulse -> shots_left=3.
// - Assert reset mid-TARGET -> flash_mode=0, busy=0 asynchronously; no hit/miss pulse afterwards.
// - BLACK_FRAME_CHECK_EN: detect high in black frame and 20 cycles in target -> miss; without macro -> hit.

Source files
------------

// File: rtl/shot_sequencer_if.sv
// Light-gun shot controller bundle: gun/vga inputs and
// pattern_gen/score outputs of shot_sequencer.
interface shot_sequencer_if #(
   parameter int SCORE_W = 8
);
   logic               trigger;
   logic               detect;
   logic               frame_start;
   logic               valid;
   logic               new_round;
   logic [1:0]         flash_mode;
   logic               busy;
   logic               hit;
   logic               miss;
   logic [SCORE_W-1:0] score;
   logic [1:0]         shots_left;

   modport master (
      output trigger, detect, frame_start, valid, new_round,
      input  flash_mode, busy, hit, miss, score, shots_left
   );

   modport slave (
      input  trigger, detect, frame_start, valid, new_round,
      output flash_mode, busy, hit, miss, score, shots_left
   );
endinterface

// File: rtl/shot_sequencer.sv
// Light-gun shot sequencer: flashes black/target frames, scores hits.
// Optional black-frame cheat check: define BLACK_FRAME_CHECK_EN.
module shot_sequencer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int BLACK_FRAMES    = 1,
   parameter int TARGET_FRAMES   = 1,
   parameter int DETECT_MIN      = 16,
   parameter int SHOTS           = 3,
   parameter int SCORE_W         = 8
) (
   input logic             clk,
   input logic             reset,
   shot_sequencer_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DT_W = $clog2(DETECT_MIN + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DT_W-1:0] DT_MIN = DT_W'(DETECT_MIN);
   localparam logic [1:0]      BF     = 2'(BLACK_FRAMES);
   localparam logic [1:0]      TF     = 2'(TARGET_FRAMES);
   localparam logic [1:0]      SH     = 2'(SHOTS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_BLACK,
      S_TARGET,
      S_RESOLVE,
      S_RELEASE
   } state_t;

   logic [1:0]         r_trig_s;
   logic [1:0]         r_det_s;
   logic [DB_W-1:0]    r_db_cnt;
   logic               r_trig_db;
   logic               r_trig_db_d;

   state_t             r_state,  w_state_n;
   logic [1:0]         r_flash,  w_flash_n;
   logic               r_busy,   w_busy_n;
   logic               r_hit,    w_hit_n;
   logic               r_miss,   w_miss_n;
   logic [SCORE_W-1:0] r_score,  w_score_n;
   logic [1:0]         r_shots,  w_shots_n;
   logic [1:0]         r_frame,  w_frame_n;
   logic [DT_W-1:0]    r_det,    w_det_n;

   logic               w_trig_sync;
   logic               w_det_v;
   logic               w_press;
   logic               w_cheat;
   logic               w_is_hit;

`ifdef BLACK_FRAME_CHECK_EN
   logic               r_cheat,  w_cheat_n;
   assign w_cheat = r_cheat;
`else
   assign w_cheat = 1'b0;
`endif

   assign w_trig_sync = r_trig_s[1];
   assign w_det_v     = r_det_s[1] & bus.valid;
   assign w_press     = r_trig_db & ~r_trig_db_d;

   // Any change of the synced level while counting returns it
   // to the debounced value, which restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_trig_s    <= '0;
         r_det_s     <= '0;
         r_db_cnt    <= '0;
         r_trig_db   <= 1'b0;
         r_trig_db_d <= 1'b0;
      end else begin
         r_trig_s    <= {r_trig_s[0], bus.trigger};
         r_det_s     <= {r_det_s[0], bus.detect};
         r_trig_db_d <= r_trig_db;
         if (w_trig_sync == r_trig_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_MAX) begin
            r_trig_db <= w_trig_sync;
            r_db_cnt  <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_flash <= 2'd0;
         r_busy  <= 1'b0;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
         r_score <= '0;
         r_shots <= SH;
         r_frame <= 2'd0;
         r_det   <= '0;
`ifdef BLACK_FRAME_CHECK_EN
         r_cheat <= 1'b0;
`endif
      end else begin
         r_state <= w_state_n;
         r_flash <= w_flash_n;
         r_busy  <= w_busy_n;
         r_hit   <= w_hit_n;
         r_miss  <= w_miss_n;
         r_score <= w_score_n;
         r_shots <= w_shots_n;
         r_frame <= w_frame_n;
         r_det   <= w_det_n;
`ifdef BLACK_FRAME_CHECK_EN
         r_cheat <= w_cheat_n;
`endif
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_flash_n = r_flash;
      w_busy_n  = r_busy;
      w_hit_n   = 1'b0;
      w_miss_n  = 1'b0;
      w_score_n = r_score;
      w_shots_n = r_shots;
      w_frame_n = r_frame;
      w_det_n   = r_det;
      w_is_hit  = 1'b0;
`ifdef BLACK_FRAME_CHECK_EN
      w_cheat_n = r_cheat;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_press && (r_shots != 2'd0)) begin
               w_state_n = S_ARM;
               w_shots_n = r_shots - 2'd1;
               w_busy_n  = 1'b1;
               w_flash_n = 2'd0;
            end
         end
         S_ARM: begin
`ifdef BLACK_FRAME_CHECK_EN
            w_cheat_n = 1'b0;
`endif
            if (bus.frame_start) begin
               w_state_n = S_BLACK;
               w_flash_n = 2'd1;
               w_frame_n = 2'd0;
               w_det_n   = '0;
            end
         end
         S_BLACK: begin
`ifdef BLACK_FRAME_CHECK_EN
            if (w_det_v) w_cheat_n = 1'b1;
`endif
            if (bus.frame_start) begin
               if (r_frame + 2'd1 == BF) begin
                  w_state_n = S_TARGET;
                  w_flash_n = 2'd2;
                  w_frame_n = 2'd0;
               end else begin
                  w_frame_n = r_frame + 2'd1;
               end
            end
         end
         S_TARGET: begin
            if (w_det_v && (r_det < DT_MIN)) begin
               w_det_n = r_det + 1'b1;
            end
            if (bus.frame_start) begin
               if (r_frame + 2'd1 == TF) begin
                  w_state_n = S_RESOLVE;
                  w_flash_n = 2'd0;
                  w_is_hit  = (w_det_n >= DT_MIN) && !w_cheat;
                  w_hit_n   = w_is_hit;
                  w_miss_n  = !w_is_hit;
                  if (w_is_hit && (r_score != {SCORE_W{1'b1}})) begin
                     w_score_n = r_score + 1'b1;
                  end
               end else begin
                  w_frame_n = r_frame + 2'd1;
               end
            end
         end
         S_RESOLVE: begin
            w_state_n = S_RELEASE;
         end
         S_RELEASE: begin
            if (!r_trig_db) begin
               w_state_n = S_IDLE;
               w_busy_n  = 1'b0;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_busy_n  = 1'b0;
            w_flash_n = 2'd0;
         end
      endcase
      // Reload takes priority over a same-cycle decrement.
      if (bus.new_round) w_shots_n = SH;
   end

   assign bus.flash_mode = r_flash;
   assign bus.busy       = r_busy;
   assign bus.hit        = r_hit;
   assign bus.miss       = r_miss;
   assign bus.score      = r_score;
   assign bus.shots_left = r_shots;

endmodule
